// File: rtl/axi_lite_clint_pkg.sv
// Shared constants, FSM state types and the byte-merge helper for the CLINT.
package clint_pkg;

    localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
    localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } clint_wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } clint_rstate_e;

    // Register targeted by a bus address; SEL_NONE answers SLVERR.
    typedef enum logic [1:0] {
        SEL_MSIP     = 2'd0,
        SEL_MTIMECMP = 2'd1,
        SEL_MTIME    = 2'd2,
        SEL_NONE     = 2'd3
    } clint_sel_e;

    // Replace byte i of old_val with byte i of new_val wherever strb[i] is set.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                               input logic [63:0] new_val,
                                               input logic [7:0]  strb);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_lite_clint_if.sv
// AXI-lite channel bundle between the MMIO hub (Master) and a slave window.
interface AXI_ift #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    // write address / data / response
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    // read address / data
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport Slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport Master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_clint_timebase.sv
// CLINT timebase: prescaler, mtime counter and mtimecmp with byte-strobe
// write ports, and the registered mtip compare.
module clint_timebase
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_we,
    input  logic        mtimecmp_we,
    input  logic [63:0] wdata,
    input  logic [7:0]  wstrb,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip
);

    localparam int unsigned    PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          mtip_q, mtip_d;
    logic          tick_s;
    logic [63:0]   mtime_inc_s;

    // Next-state: prescaler wrap, tick increment, then written bytes override.
    always_comb begin
        tick_s = (presc_q == PRESC_LAST);
        if (tick_s) begin
            presc_d     = {PW{1'b0}};
            mtime_inc_s = mtime_q + 64'd1;
        end else begin
            presc_d     = presc_q + PW'(1);
            mtime_inc_s = mtime_q;
        end
        if (mtime_we) begin
            mtime_d = byte_merge(mtime_inc_s, wdata, wstrb);
        end else begin
            mtime_d = mtime_inc_s;
        end
        if (mtimecmp_we) begin
            mtimecmp_d = byte_merge(mtimecmp_q, wdata, wstrb);
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
        mtip_d = (mtime_q >= mtimecmp_q);
    end

    // Timebase state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= {PW{1'b0}};
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
        end
    end

    assign mtime    = mtime_q;
    assign mtimecmp = mtimecmp_q;
    assign mtip     = mtip_q;

endmodule

// File: rtl/axi_lite_clint.sv
// AXI-lite core-local interruptor: address decode, independent read and
// write response FSMs, msip register, and the timebase sub-block.
module axi_lite_clint
    import clint_pkg::*;
#(
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter logic [63:0] BASE           = 64'h0000_0000_0200_0000,
    parameter int unsigned TICK_DIV       = 1
) (
    input  logic        clk,
    input  logic        rst,
    AXI_ift.Slave       slave,
    output logic        mtip,
    output logic        msip,
    output logic [63:0] mtime
);

    clint_wstate_e             wstate_q, wstate_d;
    clint_rstate_e             rstate_q, rstate_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      msip_q, msip_d;
    logic                      w_acc_s, r_acc_s;
    clint_sel_e                wsel_s, rsel_s;
    logic                      mtime_we_s, mtimecmp_we_s;
    logic [63:0]               mtime_s, mtimecmp_s;
    logic                      mtip_s;

    // Map a bus address onto a register; the low three bits are don't-care.
    function automatic clint_sel_e decode_sel(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [AXI_ADDR_WIDTH-1:0] off;
        clint_sel_e                sel;
        off      = addr - AXI_ADDR_WIDTH'(BASE);
        off[2:0] = 3'b000;
        if (off == AXI_ADDR_WIDTH'(CLINT_MSIP_OFF)) begin
            sel = SEL_MSIP;
        end else if (off == AXI_ADDR_WIDTH'(CLINT_MTIMECMP_OFF)) begin
            sel = SEL_MTIMECMP;
        end else if (off == AXI_ADDR_WIDTH'(CLINT_MTIME_OFF)) begin
            sel = SEL_MTIME;
        end else begin
            sel = SEL_NONE;
        end
        return sel;
    endfunction

    // Write channel: accept AW+W together in idle, update target, hold B until bready.
    always_comb begin
        w_acc_s       = ~rst & (wstate_q == W_IDLE) & slave.awvalid & slave.wvalid;
        wsel_s        = decode_sel(slave.awaddr);
        wstate_d      = wstate_q;
        bresp_d       = bresp_q;
        msip_d        = msip_q;
        mtime_we_s    = 1'b0;
        mtimecmp_we_s = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (w_acc_s) begin
                    wstate_d = W_RESP;
                    case (wsel_s)
                        SEL_MSIP: begin
                            bresp_d = RESP_OKAY;
                            if (slave.wstrb[0]) begin
                                msip_d = slave.wdata[0];
                            end else begin
                                msip_d = msip_q;
                            end
                        end
                        SEL_MTIMECMP: begin
                            bresp_d       = RESP_OKAY;
                            mtimecmp_we_s = 1'b1;
                        end
                        SEL_MTIME: begin
                            bresp_d    = RESP_OKAY;
                            mtime_we_s = 1'b1;
                        end
                        default: begin
                            bresp_d = RESP_SLVERR;
                        end
                    endcase
                end else begin
                    wstate_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (slave.bready) begin
                    wstate_d = W_IDLE;
                end else begin
                    wstate_d = W_RESP;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Read channel: capture pre-update register contents on acceptance, hold until rready.
    always_comb begin
        r_acc_s  = ~rst & (rstate_q == R_IDLE) & slave.arvalid;
        rsel_s   = decode_sel(slave.araddr);
        rstate_d = rstate_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        case (rstate_q)
            R_IDLE: begin
                if (r_acc_s) begin
                    rstate_d = R_RESP;
                    case (rsel_s)
                        SEL_MSIP: begin
                            rresp_d = RESP_OKAY;
                            rdata_d = AXI_DATA_WIDTH'({63'd0, msip_q});
                        end
                        SEL_MTIMECMP: begin
                            rresp_d = RESP_OKAY;
                            rdata_d = AXI_DATA_WIDTH'(mtimecmp_s);
                        end
                        SEL_MTIME: begin
                            rresp_d = RESP_OKAY;
                            rdata_d = AXI_DATA_WIDTH'(mtime_s);
                        end
                        default: begin
                            rresp_d = RESP_SLVERR;
                            rdata_d = {AXI_DATA_WIDTH{1'b0}};
                        end
                    endcase
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_RESP: begin
                if (slave.rready) begin
                    rstate_d = R_IDLE;
                end else begin
                    rstate_d = R_RESP;
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // Both response FSMs and the msip bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            bresp_q  <= 2'b00;
            rresp_q  <= 2'b00;
            rdata_q  <= {AXI_DATA_WIDTH{1'b0}};
            msip_q   <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            bresp_q  <= bresp_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            msip_q   <= msip_d;
        end
    end

    clint_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .clk         (clk),
        .rst         (rst),
        .mtime_we    (mtime_we_s),
        .mtimecmp_we (mtimecmp_we_s),
        .wdata       (slave.wdata),
        .wstrb       (slave.wstrb),
        .mtime       (mtime_s),
        .mtimecmp    (mtimecmp_s),
        .mtip        (mtip_s)
    );

    assign slave.awready = w_acc_s;
    assign slave.wready  = w_acc_s;
    assign slave.bvalid  = (wstate_q == W_RESP);
    assign slave.bresp   = bresp_q;
    assign slave.arready = r_acc_s;
    assign slave.rvalid  = (rstate_q == R_RESP);
    assign slave.rresp   = rresp_q;
    assign slave.rdata   = rdata_q;

    assign mtip  = mtip_s;
    assign msip  = msip_q;
    assign mtime = mtime_s;

endmodule

// File: tb/tb_axi_lite_clint.sv
// Randomised self-checking bench for axi_lite_clint with a behavioural model
// of the register map, plus directed scenarios with hand-computed values.
module tb_axi_lite_clint;
    import clint_pkg::*;

    localparam logic [63:0] BASE     = 64'h0000_0000_0200_0000;
    localparam logic [63:0] A_MSIP   = BASE + 64'h0000;
    localparam logic [63:0] A_CMP    = BASE + 64'h4000;
    localparam logic [63:0] A_MTIME  = BASE + 64'hBFF8;
    localparam logic [63:0] A_BAD    = BASE + 64'h0100;
    localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    AXI_ift #(.ADDR_W(64), .DATA_W(64)) bus  ();
    AXI_ift #(.ADDR_W(64), .DATA_W(64)) bus3 ();

    logic        mtip, msip, mtip3, msip3;
    logic [63:0] mtime, mtime3;

    axi_lite_clint #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .BASE(BASE), .TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .slave(bus), .mtip(mtip), .msip(msip), .mtime(mtime));

    axi_lite_clint #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .BASE(BASE), .TICK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .slave(bus3), .mtip(mtip3), .msip(msip3), .mtime(mtime3));

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [63:0] m_mtime, m_cmp, m_rdata;
    logic        m_msip, m_mtip, m_wpend, m_rpend;
    logic [1:0]  m_bresp, m_rresp;
    longint      m_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    // 0 = msip, 1 = mtimecmp, 2 = mtime, 3 = unmapped
    function automatic int which(input logic [63:0] addr);
        logic [63:0] off;
        off = (addr - BASE) & 64'hFFFF_FFFF_FFFF_FFF8;
        if (off == 64'h0000) return 0;
        else if (off == 64'h4000) return 1;
        else if (off == 64'hBFF8) return 2;
        else return 3;
    endfunction

    task automatic model_step();
        logic [63:0] nm;
        logic        nmtip;
        if (rst) begin
            m_mtime = 64'd0; m_cmp = ONES; m_msip = 1'b0; m_mtip = 1'b0;
            m_wpend = 1'b0; m_rpend = 1'b0; m_bresp = 2'b00; m_rresp = 2'b00;
            m_rdata = 64'd0; m_cyc = 0;
        end else begin
            nmtip = (m_mtime >= m_cmp);
            nm    = m_mtime + 64'd1;
            if (!m_rpend && bus.arvalid) begin
                m_rpend = 1'b1;
                case (which(bus.araddr))
                    0: begin m_rdata = {63'd0, m_msip}; m_rresp = 2'b00; end
                    1: begin m_rdata = m_cmp;   m_rresp = 2'b00; end
                    2: begin m_rdata = m_mtime; m_rresp = 2'b00; end
                    default: begin m_rdata = 64'd0; m_rresp = 2'b10; end
                endcase
            end else if (m_rpend && bus.rready) begin
                m_rpend = 1'b0;
            end
            if (!m_wpend && bus.awvalid && bus.wvalid) begin
                m_wpend = 1'b1;
                m_bresp = 2'b00;
                case (which(bus.awaddr))
                    0: if (bus.wstrb[0]) m_msip = bus.wdata[0];
                    1: m_cmp = merge(m_cmp, bus.wdata, bus.wstrb);
                    2: nm = merge(nm, bus.wdata, bus.wstrb);
                    default: m_bresp = 2'b10;
                endcase
            end else if (m_wpend && bus.bready) begin
                m_wpend = 1'b0;
            end
            m_mtime = nm;
            m_mtip  = nmtip;
            m_cyc   = m_cyc + 1;
        end
    endtask

    // Model advances on every rising edge.
    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare process: all outputs against the model, shortly after each edge.
    initial forever begin
        @(posedge clk);
        #1;
        chk("awready", {63'd0, bus.awready}, {63'd0, !rst && !m_wpend && bus.awvalid && bus.wvalid});
        chk("wready",  {63'd0, bus.wready},  {63'd0, !rst && !m_wpend && bus.awvalid && bus.wvalid});
        chk("arready", {63'd0, bus.arready}, {63'd0, !rst && !m_rpend && bus.arvalid});
        chk("bvalid",  {63'd0, bus.bvalid},  {63'd0, m_wpend});
        chk("bresp",   {62'd0, bus.bresp},   {62'd0, m_bresp});
        chk("rvalid",  {63'd0, bus.rvalid},  {63'd0, m_rpend});
        chk("rresp",   {62'd0, bus.rresp},   {62'd0, m_rresp});
        chk("rdata",   bus.rdata, m_rdata);
        chk("mtime",   mtime, m_mtime);
        chk("mtip",    {63'd0, mtip}, {63'd0, m_mtip});
        chk("msip",    {63'd0, msip}, {63'd0, m_msip});
        chk("mtime_div3", mtime3, 64'(m_cyc / 3));
        chk("mtip_div3",  {63'd0, mtip3}, 64'd0);
    end

    task automatic axi_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb,
                             input int hold_b, input bit keep_valid, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        #1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) chk("aw_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        if (!keep_valid) begin bus.awvalid = 1'b0; bus.wvalid = 1'b0; end
        repeat (hold_b) @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        #1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) chk("b_timeout", 64'd0, 64'd1);
        resp = bus.bresp;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [63:0] addr, input int hold_r,
                            output logic [63:0] data, output logic [1:0] resp);
        int n;
        @(negedge clk);
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b0;
        #1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) chk("ar_accept_timeout", 64'd0, 64'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        repeat (hold_r) @(negedge clk);
        bus.rready = 1'b1;
        #1;
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) chk("r_timeout", 64'd0, 64'd1);
        data = bus.rdata;
        resp = bus.rresp;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    function automatic logic [63:0] pick_addr();
        case ($urandom % 6)
            0: return A_MSIP;
            1: return A_CMP;
            2: return A_MTIME;
            3: return A_CMP + 64'($urandom % 8);
            4: return A_BAD + 64'(8 * ($urandom % 16));
            default: return BASE - 64'd8;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd, pre;
        logic [1:0]  rr, wr;
        int          n;

        bus.awaddr = 64'd0; bus.awvalid = 1'b0; bus.wdata = 64'd0; bus.wstrb = 8'd0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = 64'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus3.awaddr = 64'd0; bus3.awvalid = 1'b0; bus3.wdata = 64'd0; bus3.wstrb = 8'd0;
        bus3.wvalid = 1'b0; bus3.bready = 1'b0; bus3.araddr = 64'd0; bus3.arvalid = 1'b0; bus3.rready = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset, ten idle cycles
        repeat (10) @(posedge clk);
        #1;
        chk("mtime_after_10", mtime, 64'd10);
        chk("mtip_idle", {63'd0, mtip}, 64'd0);
        axi_read(A_CMP, 0, rd, rr);
        chk("cmp_reset_data", rd, ONES);
        chk("cmp_reset_resp", {62'd0, rr}, 64'd0);

        // Timer compare at 20
        axi_write(A_CMP, 64'd20, 8'hFF, 0, 1'b0, wr);
        chk("cmp_write_resp", {62'd0, wr}, 64'd0);
        n = 0;
        @(posedge clk); #1;
        while (mtime != 64'd20 && n < 100) begin @(posedge clk); #1; n++; end
        chk("mtime_reaches_20", mtime, 64'd20);
        chk("mtip_at_20", {63'd0, mtip}, 64'd0);
        @(posedge clk); #1;
        chk("mtip_after_20", {63'd0, mtip}, 64'd1);
        axi_write(A_CMP, ONES, 8'hFF, 0, 1'b0, wr);
        chk("mtip_cleared", {63'd0, mtip}, 64'd0);

        // MSIP set / read / strobe-0 / clear
        axi_write(A_MSIP, 64'h1, 8'h01, 0, 1'b0, wr);
        chk("msip_set", {63'd0, msip}, 64'd1);
        axi_read(A_MSIP, 1, rd, rr);
        chk("msip_read", rd, 64'h1);
        axi_write(A_MSIP, 64'h0, 8'h00, 0, 1'b0, wr);
        chk("msip_strb0", {63'd0, msip}, 64'd1);
        chk("msip_strb0_resp", {62'd0, wr}, 64'd0);
        axi_write(A_MSIP, 64'hFE, 8'h01, 0, 1'b0, wr);
        chk("msip_clear", {63'd0, msip}, 64'd0);

        // Partial MTIME write: upper word kept, lower word zeroed
        axi_write(A_MTIME, 64'h0000_0001_0000_0003, 8'hFF, 0, 1'b0, wr);
        axi_write(A_MTIME, 64'd0, 8'h0F, 0, 1'b0, wr);
        chk("mtime_partial_hi", {32'd0, mtime[63:32]}, 64'd1);
        chk("mtime_partial_lo_small", {63'd0, (mtime[31:0] < 32'd16)}, 64'd1);

        // Unmapped window: SLVERR read and held-off write response
        axi_read(A_BAD, 0, rd, rr);
        chk("bad_read_resp", {62'd0, rr}, 64'h2);
        chk("bad_read_data", rd, 64'd0);
        axi_write(A_BAD, ONES, 8'hFF, 5, 1'b1, wr);
        chk("bad_write_resp", {62'd0, wr}, 64'h2);
        chk("bad_write_msip", {63'd0, msip}, 64'd0);

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            logic [63:0] wa, ra, wd, rdat;
            logic [7:0]  ws;
            logic [1:0]  wrs, rrs;
            int          op, hb, hr;
            wa = pick_addr(); ra = pick_addr();
            wd = {$urandom, $urandom};
            if ($urandom % 8 == 0) wd = 64'hFFFF_FFFF_FFFF_FFFE;
            if ($urandom % 6 == 0) wd = m_mtime + 64'd4;
            ws = 8'($urandom);
            if ($urandom % 3 == 0) ws = 8'hFF;
            hb = int'($urandom % 3); hr = int'($urandom % 3); op = int'($urandom % 3);
            case (op)
                0: axi_write(wa, wd, ws, hb, 1'b0, wrs);
                1: axi_read(ra, hr, rdat, rrs);
                default: fork
                    axi_write(wa, wd, ws, hb, 1'b0, wrs);
                    axi_read(ra, hr, rdat, rrs);
                join
            endcase
        end

        // Simultaneous MTIME read and write, then reset with read pending
        @(negedge clk);
        bus.awaddr = A_MTIME; bus.wdata = 64'd5; bus.wstrb = 8'hFF; bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = A_MTIME; bus.arvalid = 1'b1; bus.rready = 1'b0; bus.bready = 1'b1;
        pre = m_mtime;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        #1;
        chk("simul_rvalid", {63'd0, bus.rvalid}, 64'd1);
        chk("simul_rdata_prewrite", bus.rdata, pre);
        chk("simul_mtime_written", mtime, 64'd5);
        @(negedge clk);
        bus.bready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_rvalid", {63'd0, bus.rvalid}, 64'd0);
        chk("rst_mtime", mtime, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_clint.md
# axi_lite_clint

Core-local interruptor (machine timer plus software interrupt) as an AXI-lite MMIO slave. It sits directly downstream of the MMIO hub on one of its slave ports and decodes only its own offset window. It provides `mtime`, `mtimecmp` and `msip` registers, and drives the machine timer and software interrupt lines into the core's CSR/trap logic.

## Interface
Parameters:
- `AXI_ADDR_WIDTH`, 64, address width of the AXI_ift.
- `AXI_DATA_WIDTH`, 64, data width; the block supports only 64.
- `BASE`, 64'h0200_0000, byte base address of the window. It equals the hub's MEMn_BEGIN for this port.
- `TICK_DIV`, 1, number of `clk` cycles per `mtime` increment (≥1).

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `slave`  AXI_ift.Slave  -  AXI-lite channel bundle (Mw/Mr in, Sw/Sr out) from the hub.
- `mtip`  out  1  machine timer interrupt pending.
- `msip`  out  1  machine software interrupt pending.
- `mtime`  out  64  current timer value, for the `time` CSR.

## Operation
Register map. The offset is `addr - BASE`, and bits [2:0] are ignored.
- 0x0000 MSIP: bit 0 holds `msip`; other bits read 0 and writes to them are ignored.
- 0x4000 MTIMECMP: 64 bits, read/write.
- 0xBFF8 MTIME: 64 bits, read/write.
- Any other offset returns SLVERR: `bresp` or `rresp` = 2'b10, `rdata` = 0, and no register changes.

Writes merge by byte: for each i, byte i is written only if `wstrb[i]` is set. `wstrb` = 0 is an OKAY no-op.

Prescaler:
- A counter runs 0..TICK_DIV-1 and wraps.
- `mtime` increments by 1 (mod 2^64) on the wrap.
- When TICK_DIV = 1, `mtime` increments every cycle.

`mtip` is registered: `mtip` <= (`mtime` >= `mtimecmp`), an unsigned 64-bit compare using the current-cycle register values.

Write FSM: W_IDLE → W_RESP.
- In W_IDLE, `awready` = `wready` = `awvalid & wvalid`, combinational. Address and data are accepted only together, in one cycle.
- On acceptance, the register update happens at that clock edge, the response code is registered, and the FSM moves to W_RESP.
- In W_RESP, `bvalid` = 1 and `awready`/`wready` = 0. When `bvalid & bready` the FSM returns to W_IDLE, and a new write may be accepted in the cycle after that.

Read FSM: R_IDLE → R_RESP.
- In R_IDLE, `arready` = `arvalid`.
- On acceptance, `rdata`/`rresp` are registered from the current register values (the pre-update `mtime`) and the FSM moves to R_RESP.
- In R_RESP, `rvalid` = 1 and is held, with `rdata` stable, until `rready`.

The read and write FSMs are independent. A read and a write may be accepted in the same cycle; the read returns the pre-write value.

Collision rules:
- A write to MTIME in the same cycle as a tick: the written bytes win, the unwritten bytes take the incremented value, and the prescaler is not reset.
- A write to MTIMECMP: `mtip` reflects the new value one cycle after the write edge.

## Timing
- Reset values: `mtime` 0, prescaler 0, `mtimecmp` all-ones, `msip` 0, `mtip` 0, FSMs in IDLE, `bvalid`/`rvalid` 0, `bresp`/`rresp`/`rdata` 0.
- Ready outputs are 0 while `rst` is high and whenever the valids are low.
- Write latency: acceptance at edge N; `bvalid` is high from cycle N+1. The `msip` output changes at edge N.
- Read latency: acceptance at edge N; `rvalid` with data is high from cycle N+1.
- Because the hub routes responses by the live address, the master holds `awaddr`/`araddr` until its B/R handshake completes. The block itself latches nothing beyond the response.
- Throughput is at most one write per 2 cycles and one read per 2 cycles.
- Reset asserted mid-transaction drops any pending `bvalid`/`rvalid` at the next edge. No response is produced for the aborted access.

## Structure
- The shared package `clint_pkg` holds:
  - offset constants `CLINT_MSIP_OFF`, `CLINT_MTIMECMP_OFF`, `CLINT_MTIME_OFF`;
  - `RESP_OKAY` = 2'b00 and `RESP_SLVERR` = 2'b10;
  - FSM enums `clint_wstate_e` and `clint_rstate_e`.
- One sub-module, `clint_timebase`, holds the prescaler, the `mtime` counter with byte-strobe write port, and the `mtip` compare. The top level holds the decode and both FSMs.

## Test plan
- Reset, then idle 10 cycles with TICK_DIV = 1 → `mtime` = 10; `mtip` = 0; `mtimecmp` reads back all-ones with OKAY.
- Write MTIMECMP = 20 (full strobe) → `bvalid` one cycle after acceptance. `mtip` rises exactly in the cycle after `mtime` first equals 20. Writing MTIMECMP = all-ones then clears `mtip` one cycle after the write edge.
- Write 0x1 to MSIP with `wstrb` = 8'h01 → `msip` = 1. A read of 0x0000 returns 64'h1. Writing 0xFE clears it. A write with `wstrb` = 0 leaves it unchanged.
- Write MTIME with `wstrb` = 8'h0F and data 0 while `mtime` = 64'h1_0000_0005 → upper word kept, lower word = 0.
- Read and write to offset 0x0100 → SLVERR, `rdata` = 0, no state change. Hold `bready` low 5 cycles → `bvalid` and `bresp` stay stable and no second write is accepted.
- Simultaneous read of MTIME and write of MTIME = 5, then assert `rst` while the read response is pending → read returns the pre-write value; after reset `rvalid` = 0 and `mtime` = 0.
